// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: access size codes, response FSM states and the
// response register captured at grant time.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [0:0] {
        StIdle,
        StResp
    } state_e;

    typedef struct packed {
        logic       port;
        logic [1:0] offset;
        logic [1:0] size;
        logic       uns;
        logic       is_read;
        logic       err;
    } resp_t;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane helper: store-side lane replication and byte enables, load-side extract and
// sign/zero extension.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        uns,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    assign shifted = ld_word >> {offset, 3'b000};

    always_comb begin
        be       = 4'h0;
        st_lanes = 32'h0;
        ld_data  = 32'h0;
        case (size)
            SZ_B: begin
                be       = 4'b0001 << offset;
                st_lanes = {4{st_data[7:0]}};
                ld_data  = {{24{~uns & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                be       = 4'b0011 << offset;
                st_lanes = {2{st_data[15:0]}};
                ld_data  = {{16{~uns & shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                be       = 4'hF;
                st_lanes = st_data;
                ld_data  = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous data memory, with
// alignment/range checking and a one-deep pipelined response path.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned WADDR_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               p0_req,
    input  logic               p0_we,
    input  logic [ADDR_W-1:0]  p0_addr,
    input  logic [31:0]        p0_wdata,
    input  logic [1:0]         p0_size,
    input  logic               p0_unsigned,
    output logic               p0_gnt,
    output logic               p0_rvalid,
    output logic [31:0]        p0_rdata,
    output logic               p0_err,
    input  logic               p1_req,
    input  logic               p1_we,
    input  logic [ADDR_W-1:0]  p1_addr,
    input  logic [31:0]        p1_wdata,
    input  logic [1:0]         p1_size,
    input  logic               p1_unsigned,
    output logic               p1_gnt,
    output logic               p1_rvalid,
    output logic [31:0]        p1_rdata,
    output logic               p1_err,
    input  logic               p1_lock,
    output logic               mem_en,
    output logic               mem_we,
    output logic [WADDR_W-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    output logic [3:0]         mem_be,
    input  logic [31:0]        mem_rdata
);

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS) << 2;

    state_e            state_q, state_d;
    resp_t             resp_q, resp_d;
    logic              prio_q, prio_d;  // 0 favours p0 on a tie
    logic              lock_q, lock_d;
    logic              lock_eff, gnt_any;
    logic              sel_we, sel_uns, sel_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata, req_st, ld_data;
    logic [1:0]        sel_size;
    logic [3:0]        req_be;
    logic [31:0]       req_ld_unused, resp_st_unused;
    logic [3:0]        resp_be_unused;

    // A dropped p1_lock releases the lock in the same cycle it is seen.
    assign lock_eff = lock_q & p1_lock;

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (lock_eff) begin
                p1_gnt = p1_req;
            end else if (p0_req && p1_req) begin
                p0_gnt = ~prio_q;
                p1_gnt = prio_q;
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end
    end

    assign gnt_any   = p0_gnt | p1_gnt;
    assign sel_we    = p1_gnt ? p1_we       : p0_we;
    assign sel_addr  = p1_gnt ? p1_addr     : p0_addr;
    assign sel_wdata = p1_gnt ? p1_wdata    : p0_wdata;
    assign sel_size  = p1_gnt ? p1_size     : p0_size;
    assign sel_uns   = p1_gnt ? p1_unsigned : p0_unsigned;

    assign sel_err = (sel_size == 2'd3)
                   | ((sel_size == SZ_H) & sel_addr[0])
                   | ((sel_size == SZ_W) & (|sel_addr[1:0]))
                   | ({1'b0, sel_addr} >= ADDR_LIMIT);

    dmem_lane u_req_lane (
        .size     (sel_size),
        .offset   (sel_addr[1:0]),
        .uns      (sel_uns),
        .st_data  (sel_wdata),
        .ld_word  (32'h0),
        .be       (req_be),
        .st_lanes (req_st),
        .ld_data  (req_ld_unused)
    );

    assign mem_en    = gnt_any & ~sel_err;
    assign mem_we    = mem_en & sel_we;
    assign mem_addr  = mem_en ? sel_addr[WADDR_W+1:2] : '0;
    assign mem_be    = mem_en ? (sel_we ? req_be : 4'hF) : 4'h0;
    assign mem_wdata = mem_we ? req_st : 32'h0;

    always_comb begin
        prio_d = prio_q;
        if (p0_gnt) prio_d = 1'b1;
        else if (p1_gnt) prio_d = 1'b0;

        lock_d = lock_q;
        if (p1_gnt && p1_lock) lock_d = 1'b1;
        else if (!p1_lock) lock_d = 1'b0;

        resp_d = resp_q;
        if (gnt_any) begin
            resp_d.port    = p1_gnt;
            resp_d.offset  = sel_addr[1:0];
            resp_d.size    = sel_size;
            resp_d.uns     = sel_uns;
            resp_d.is_read = ~sel_we;
            resp_d.err     = sel_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
            lock_q <= 1'b0;
            resp_q <= '0;
        end else begin
            prio_q <= prio_d;
            lock_q <= lock_d;
            resp_q <= resp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = gnt_any ? StResp : StIdle;
    end

    dmem_lane u_resp_lane (
        .size     (resp_q.size),
        .offset   (resp_q.offset),
        .uns      (resp_q.uns),
        .st_data  (32'h0),
        .ld_word  (mem_rdata),
        .be       (resp_be_unused),
        .st_lanes (resp_st_unused),
        .ld_data  (ld_data)
    );

    always_comb begin
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        p0_rdata  = 32'h0;
        p1_rdata  = 32'h0;
        p0_err    = 1'b0;
        p1_err    = 1'b0;
        if (state_q == StResp && !rst) begin
            if (resp_q.port) begin
                p1_rvalid = 1'b1;
                p1_err    = resp_q.err;
                p1_rdata  = (resp_q.is_read && !resp_q.err) ? ld_data : 32'h0;
            end else begin
                p0_rvalid = 1'b1;
                p0_err    = resp_q.err;
                p0_rdata  = (resp_q.is_read && !resp_q.err) ? ld_data : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers push expected responses at grant time, a monitor
// pops and compares on every rvalid.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned WADDR_W   = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               p0_req, p0_we, p0_unsigned, p0_gnt, p0_rvalid, p0_err;
    logic [ADDR_W-1:0]  p0_addr;
    logic [31:0]        p0_wdata, p0_rdata;
    logic [1:0]         p0_size;
    logic               p1_req, p1_we, p1_unsigned, p1_gnt, p1_rvalid, p1_err, p1_lock;
    logic [ADDR_W-1:0]  p1_addr;
    logic [31:0]        p1_wdata, p1_rdata;
    logic [1:0]         p1_size;
    logic               mem_en, mem_we;
    logic [WADDR_W-1:0] mem_addr;
    logic [31:0]        mem_wdata, mem_rdata;
    logic [3:0]         mem_be;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W    (ADDR_W),
        .MEM_WORDS (MEM_WORDS),
        .WADDR_W   (WADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .p0_req      (p0_req),
        .p0_we       (p0_we),
        .p0_addr     (p0_addr),
        .p0_wdata    (p0_wdata),
        .p0_size     (p0_size),
        .p0_unsigned (p0_unsigned),
        .p0_gnt      (p0_gnt),
        .p0_rvalid   (p0_rvalid),
        .p0_rdata    (p0_rdata),
        .p0_err      (p0_err),
        .p1_req      (p1_req),
        .p1_we       (p1_we),
        .p1_addr     (p1_addr),
        .p1_wdata    (p1_wdata),
        .p1_size     (p1_size),
        .p1_unsigned (p1_unsigned),
        .p1_gnt      (p1_gnt),
        .p1_rvalid   (p1_rvalid),
        .p1_rdata    (p1_rdata),
        .p1_err      (p1_err),
        .p1_lock     (p1_lock),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_rdata   (mem_rdata)
    );

    // Synchronous single-port memory model
    logic [31:0] mem [MEM_WORDS];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct packed {
        logic        port;
        logic [31:0] cycle;
    } glog_t;

    exp_t  q0[$];
    exp_t  q1[$];
    glog_t glog[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t  e;
        glog_t g;
        if (p0_rvalid) begin
            if (q0.size() == 0) check("p0 unexpected rvalid", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                check("p0 err", {31'd0, p0_err}, {31'd0, e.err});
                check("p0 rdata", p0_rdata, e.rdata);
            end
        end
        if (p1_rvalid) begin
            if (q1.size() == 0) check("p1 unexpected rvalid", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("p1 err", {31'd0, p1_err}, {31'd0, e.err});
                check("p1 rdata", p1_rdata, e.rdata);
            end
        end
        if (p0_gnt || p1_gnt) begin
            check("single grant", {31'd0, p0_gnt & p1_gnt}, 32'd0);
            g.port  = p1_gnt;
            g.cycle = cyc;
            glog.push_back(g);
        end
    end

    // Drives one request and returns at the negedge of its grant cycle, fields still applied.
    task automatic issue(input bit port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                         input logic lock, input bit push, input logic exp_err,
                         input logic [31:0] exp_rdata);
        bit   got = 1'b0;
        exp_t e;
        @(posedge clk);
        #1;
        if (port == 1'b0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
            p0_size = size; p0_unsigned = uns;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
            p1_size = size; p1_unsigned = uns; p1_lock = lock;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((port == 1'b0 && p0_gnt) || (port == 1'b1 && p1_gnt)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check(port ? "p1 grant timeout" : "p0 grant timeout", 32'd0, 32'd1);
        end else if (push) begin
            e.err   = exp_err;
            e.rdata = exp_rdata;
            if (port) q1.push_back(e);
            else      q0.push_back(e);
        end
    endtask

    task automatic idle0();
        @(posedge clk);
        #1;
        p0_req = 1'b0;
    endtask

    task automatic idle1();
        @(posedge clk);
        #1;
        p1_req  = 1'b0;
        p1_lock = 1'b0;
    endtask

    function automatic logic any_out();
        return |{p0_gnt, p0_rvalid, p0_rdata, p0_err, p1_gnt, p1_rvalid, p1_rdata, p1_err,
                 mem_en, mem_we, mem_addr, mem_wdata, mem_be};
    endfunction

    initial begin
        rst = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_size = SZ_W;
        p0_unsigned = 1'b0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_size = SZ_W;
        p1_unsigned = 1'b0; p1_lock = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("outputs zero in reset", {31'd0, any_out()}, 32'd0);
        end
        @(posedge clk);
        #1;
        p0_req = 1'b0;
        rst    = 1'b0;

        // Word store then word load on p0
        issue(0, 1, 32'h0, 32'd123, SZ_W, 0, 0, 1, 0, 32'd0);
        check("store mem_be", {28'd0, mem_be}, 32'hF);
        check("store mem_we", {31'd0, mem_we}, 32'd1);
        check("store mem_wdata", mem_wdata, 32'd123);
        idle0();
        @(negedge clk);
        check("store rvalid at T+1", {31'd0, p0_rvalid}, 32'd1);
        issue(0, 0, 32'h0, 32'h0, SZ_W, 0, 0, 1, 0, 32'd123);
        check("load mem_be", {28'd0, mem_be}, 32'hF);
        idle0();
        @(negedge clk);
        check("load rvalid at T+1", {31'd0, p0_rvalid}, 32'd1);
        check("load no p1 rvalid", {31'd0, p1_rvalid}, 32'd0);

        // Sub-word loads and a byte store
        issue(0, 1, 32'h0, 32'h80FF_0000, SZ_W, 0, 0, 1, 0, 32'd0);
        issue(0, 0, 32'h3, 32'h0, SZ_B, 0, 0, 1, 0, 32'hFFFF_FF80);
        issue(0, 0, 32'h3, 32'h0, SZ_B, 1, 0, 1, 0, 32'h0000_0080);
        issue(0, 0, 32'h2, 32'h0, SZ_H, 0, 0, 1, 0, 32'hFFFF_80FF);
        issue(0, 0, 32'h2, 32'h0, SZ_H, 1, 0, 1, 0, 32'h0000_80FF);
        issue(0, 1, 32'h1, 32'h0000_00AB, SZ_B, 0, 0, 1, 0, 32'd0);
        check("byte store mem_be", {28'd0, mem_be}, 32'h2);
        check("byte store mem_wdata", mem_wdata, 32'hABAB_ABAB);
        issue(0, 0, 32'h0, 32'h0, SZ_W, 0, 0, 1, 0, 32'h80FF_AB00);
        idle0();
        repeat (2) @(negedge clk);

        // Both ports request continuously: p0 went last, so p1 leads
        glog.delete();
        fork
            begin
                for (int i = 0; i < 3; i++)
                    issue(0, 0, 32'h0, 32'h0, SZ_W, 0, 0, 1, 0, 32'h80FF_AB00);
                idle0();
            end
            begin
                for (int i = 0; i < 3; i++)
                    issue(1, 1, 32'(4 * (i + 1)), 32'(17 * (i + 1)), SZ_W, 0, 0, 1, 0, 32'd0);
                idle1();
            end
        join
        repeat (2) @(negedge clk);
        check("alternation grant count", glog.size(), 32'd6);
        for (int i = 0; i < glog.size(); i++) begin
            check("alternation port", {31'd0, glog[i].port}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("alternation cycle", glog[i].cycle - glog[0].cycle, 32'(i));
        end

        // p1 locks for three grants while p0 waits
        glog.delete();
        fork
            begin
                issue(1, 0, 32'h4, 32'h0, SZ_W, 0, 1, 1, 0, 32'd17);
                issue(1, 0, 32'h8, 32'h0, SZ_W, 0, 1, 1, 0, 32'd34);
                issue(1, 0, 32'hC, 32'h0, SZ_W, 0, 1, 1, 0, 32'd51);
                idle1();
            end
            begin
                issue(0, 0, 32'h0, 32'h0, SZ_W, 0, 0, 1, 0, 32'h80FF_AB00);
                idle0();
            end
        join
        repeat (2) @(negedge clk);
        check("lock grant count", glog.size(), 32'd4);
        for (int i = 0; i < glog.size(); i++) begin
            check("lock port", {31'd0, glog[i].port}, (i < 3) ? 32'd1 : 32'd0);
            check("lock cycle", glog[i].cycle - glog[0].cycle, 32'(i));
        end

        // Error cases: granted, no memory strobe, err response
        issue(0, 0, 32'h1, 32'h0, SZ_H, 0, 0, 1, 1, 32'd0);
        check("misaligned half mem_en", {31'd0, mem_en}, 32'd0);
        issue(0, 0, 32'h2, 32'h0, SZ_W, 0, 0, 1, 1, 32'd0);
        check("misaligned word mem_en", {31'd0, mem_en}, 32'd0);
        issue(0, 0, 32'h0, 32'h0, 2'd3, 0, 0, 1, 1, 32'd0);
        check("illegal size mem_en", {31'd0, mem_en}, 32'd0);
        issue(0, 0, 32'(MEM_WORDS * 4), 32'h0, SZ_W, 0, 0, 1, 1, 32'd0);
        check("out of range mem_en", {31'd0, mem_en}, 32'd0);
        idle0();
        issue(1, 1, 32'(MEM_WORDS * 4), 32'h5, SZ_W, 0, 0, 1, 1, 32'd0);
        check("out of range store mem_en", {31'd0, mem_en}, 32'd0);
        idle1();
        issue(1, 0, 32'(MEM_WORDS * 4 - 4), 32'h0, SZ_W, 0, 0, 1, 0, 32'hx);
        check("last word in range mem_en", {31'd0, mem_en}, 32'd1);
        idle1();
        repeat (2) @(negedge clk);
        q1.delete();

        // Reset in the cycle after a read grant drops the response
        issue(0, 0, 32'h0, 32'h0, SZ_W, 0, 0, 0, 0, 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        p0_req = 1'b0;
        @(negedge clk);
        check("outputs zero after read grant reset", {31'd0, any_out()}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("no rvalid after reset", {31'd0, p0_rvalid}, 32'd0);
        issue(0, 0, 32'h0, 32'h0, SZ_W, 0, 0, 1, 0, 32'h80FF_AB00);
        idle0();
        repeat (3) @(negedge clk);

        check("p0 responses outstanding", q0.size(), 32'd0);
        check("p1 responses outstanding", q1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

endmodule
